hm_nonce_dispatch: RTL and testbench
====================================

Name: hm_nonce_dispatch

Overview:
Work dispatcher directly upstream of the hashing module.
- Accepts a mining job: 512-bit final header block template, target difficulty, nonce range.
- Inserts successive nonces into the template and launches one hash at a time with begin_hash.
- Consumes hash_done, valid_hash_flag and valid_hash, then reports the winning nonce and hash, range exhaustion, or a hung hasher.

Parameters:
NONCE_STRIDE, 1, nonce increment per attempt (parent sets it to the number of parallel hashing modules, each module with its own nonce_start).
NONCE_WORD, 3, index of the 32-bit nonce word in the block; word 0 = bits 511:480, so the default is bits 415:384.
TIMEOUT_CYCLES, 256, cycles allowed in WAIT before the hasher is declared hung; must be >= 2.

Ports:
clk  in  1  clock (all logic on the rising edge)
rst  in  1  synchronous, active-high reset
job_start  in  1  one-cycle job request; sampled only in IDLE
abort  in  1  cancel the current job
header_tail  in  512  block template (nonce word contents ignored)
job_difficulty  in  256  target, latched on job_start
nonce_start  in  32  first nonce
nonce_end  in  32  last nonce (inclusive)
busy  out  1  high in every state except IDLE
begin_hash  out  1  one-cycle launch pulse to the hasher
quit_hash  out  1  one-cycle cancel pulse to the hasher
data_to_hash  out  512  template with the current nonce inserted, registered
difficulty  out  256  latched job_difficulty
hash_done  in  1  hasher completion pulse
valid_hash_flag  in  1  qualified by hash_done
valid_hash  in  256  qualified by hash_done and valid_hash_flag
found  out  1  one-cycle success pulse
found_nonce  out  32  winning nonce, held
found_hash  out  256  winning hash, held
exhausted  out  1  one-cycle pulse: range finished, no hit
timeout_err  out  1  sticky hung-hasher flag
hashes_tried  out  32  completed attempts this job, saturating

Behaviour:
- Reset (synchronous, rst=1 at a clock edge): state IDLE; every output and internal register is 0. Reset mid-job drops the job silently, with no quit_hash pulse.
- FSM states: IDLE, ISSUE, WAIT, FOUND, EXHAUSTED.
- IDLE: job_start=1 latches header_tail, job_difficulty, nonce_start (as current nonce) and nonce_end. It also clears found_nonce, found_hash, timeout_err and hashes_tried, then goes to ISSUE. job_start outside IDLE is ignored.
- ISSUE: begin_hash=1 for exactly this cycle; watchdog cleared; go to WAIT.
- data_to_hash is updated on the edge entering ISSUE and then held stable until the next ISSUE.
- WAIT: the watchdog counts up each cycle. On hash_done=1, hashes_tried increments (saturating at 0xFFFFFFFF), then:
  - valid_hash_flag=1: capture found_hash=valid_hash and found_nonce=current nonce; go to FOUND.
  - otherwise, compute next = nonce + NONCE_STRIDE in 33 bits. If there is a carry or next > nonce_end, go to EXHAUSTED; else nonce = next and go to ISSUE.
- Watchdog reaching TIMEOUT_CYCLES-1 without hash_done: quit_hash=1 next cycle, timeout_err=1, go to IDLE.
- FOUND: found=1 for one cycle, then IDLE. EXHAUSTED: exhausted=1 for one cycle, then IDLE.
- abort=1 in ISSUE or WAIT: quit_hash=1 on the following cycle, go to IDLE, no found/exhausted pulse. abort wins over a simultaneous hash_done or timeout. abort in IDLE, FOUND or EXHAUSTED has no effect.
- nonce_start > nonce_end: exactly one attempt at nonce_start, then EXHAUSTED.
- Latency:
  - job_start at cycle T gives begin_hash at T+1.
  - hash_done at cycle D gives the next begin_hash, or the found/exhausted pulse, at D+1.
- difficulty output is constant for the whole job.

Decomposition:
- Package hm_dispatch_pkg holds:
  - the state enum;
  - NONCE_W=32, BLOCK_W=512, HASH_W=256;
  - a function that inserts a nonce at word NONCE_WORD.
- One sub-module, hm_watchdog: counter with clear/enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Range hit: nonce_start=0x10, nonce_end=0x1F, stride 1. Model asserts valid_hash_flag on the 4th hash_done → found pulse, found_nonce=0x13, hashes_tried=4, found_hash equals the model value.
- Exhaustion: nonce_start=0xFFFFFFFE, nonce_end=0xFFFFFFFF, stride 1, never valid → exactly 2 begin_hash pulses, exhausted pulse, no wrap to 0, hashes_tried=2.
- Stride: stride 4, range 0..10 → data_to_hash word 3 takes 0, 4, 8, then exhausted; bits outside word 3 always equal header_tail.
- Abort: abort in the same cycle as hash_done with valid_hash_flag=1 → quit_hash pulse the next cycle, no found, busy=0 after.
- Timeout: TIMEOUT_CYCLES=8, hasher never responds → quit_hash 8 cycles after begin_hash, timeout_err=1 until the next job_start.
- Reset: rst asserted while in WAIT → all outputs 0 on the next edge; job_start after release begins a fresh job.

Source files
------------

// File: rtl/hm_nonce_dispatch_pkg.sv
// hm_dispatch_pkg: widths, FSM state encodings and the nonce insertion helper shared by the dispatcher files
package hm_dispatch_pkg;
  localparam int NONCE_W = 32;
  localparam int BLOCK_W = 512;
  localparam int HASH_W = 256;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_ISSUE = 3'd1;
  localparam state_t S_WAIT = 3'd2;
  localparam state_t S_FOUND = 3'd3;
  localparam state_t S_EXH = 3'd4;
  function automatic logic [BLOCK_W-1:0] insert_nonce(input logic [BLOCK_W-1:0] blk, input logic [NONCE_W-1:0] n, input int word);
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[BLOCK_W-1-word*NONCE_W -: NONCE_W] = n;
    return r;
  endfunction
endpackage

// File: rtl/hm_nonce_dispatch_if.sv
// hm_hash_if: dispatcher-to-hasher link; master drives begin/quit/data/difficulty, slave returns done/flag/hash
interface hm_hash_if;
  import hm_dispatch_pkg::*;
  logic begin_hash;
  logic quit_hash;
  logic [BLOCK_W-1:0] data_to_hash;
  logic [HASH_W-1:0] difficulty;
  logic hash_done;
  logic valid_hash_flag;
  logic [HASH_W-1:0] valid_hash;
  modport master(output begin_hash, quit_hash, data_to_hash, difficulty, input hash_done, valid_hash_flag, valid_hash);
  modport slave(input begin_hash, quit_hash, data_to_hash, difficulty, output hash_done, valid_hash_flag, valid_hash);
endinterface

// File: rtl/hm_nonce_dispatch_watchdog.sv
// hm_watchdog: cycle counter (clr_i zeroes, en_i counts); expired_o flags the cycle the count reaches TIMEOUT_CYCLES-1
module hm_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [W-1:0] cnt_q;
  assign expired_o = en_i && cnt_q == W'(TIMEOUT_CYCLES - 2);
  always_ff @(posedge clk)
    cnt_q <= (rst || clr_i) ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
endmodule

// File: rtl/hm_nonce_dispatch.sv
// hm_nonce_dispatch: walks a nonce range through one hasher (hash master port), reports found/exhausted/timeout and attempt count
module hm_nonce_dispatch
  import hm_dispatch_pkg::*;
#(
  parameter int NONCE_STRIDE = 1,
  parameter int NONCE_WORD = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic job_start,
  input  logic abort,
  input  logic [BLOCK_W-1:0] header_tail,
  input  logic [HASH_W-1:0] job_difficulty,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  output logic busy,
  output logic found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [HASH_W-1:0] found_hash,
  output logic exhausted,
  output logic timeout_err,
  output logic [NONCE_W-1:0] hashes_tried,
  hm_hash_if.master hash
);
  state_t state_q, state_d;
  logic [BLOCK_W-1:0] tail_q, tail_d, data_q, data_d;
  logic [HASH_W-1:0] diff_q, diff_d, fhash_q, fhash_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d, end_q, end_d, fnonce_q, fnonce_d, tried_q, tried_d;
  logic quit_q, quit_d, tout_q, tout_d;
  logic [NONCE_W:0] nxt;
  logic wd_exp;
  hm_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q == S_ISSUE),
    .en_i(state_q == S_WAIT),
    .expired_o(wd_exp)
  );
  assign nxt = {1'b0, nonce_q} + (NONCE_W+1)'(NONCE_STRIDE);
  always_comb begin
    state_d = state_q;
    tail_d = tail_q;
    data_d = data_q;
    diff_d = diff_q;
    fhash_d = fhash_q;
    nonce_d = nonce_q;
    end_d = end_q;
    fnonce_d = fnonce_q;
    tried_d = tried_q;
    quit_d = 1'b0;
    tout_d = tout_q;
    if (state_q == S_IDLE && job_start) begin
      tail_d = header_tail;
      diff_d = job_difficulty;
      nonce_d = nonce_start;
      end_d = nonce_end;
      data_d = insert_nonce(header_tail, nonce_start, NONCE_WORD);
      fnonce_d = '0;
      fhash_d = '0;
      tout_d = 1'b0;
      tried_d = '0;
      state_d = S_ISSUE;
    end else if ((state_q == S_ISSUE || state_q == S_WAIT) && abort) begin
      quit_d = 1'b1;
      state_d = S_IDLE;
    end else if (state_q == S_ISSUE) begin
      state_d = S_WAIT;
    end else if (state_q == S_WAIT && hash.hash_done) begin
      tried_d = &tried_q ? tried_q : tried_q + 1'b1;
      if (hash.valid_hash_flag) begin
        fhash_d = hash.valid_hash;
        fnonce_d = nonce_q;
        state_d = S_FOUND;
      end else if (nxt[NONCE_W] || nxt[NONCE_W-1:0] > end_q) begin
        state_d = S_EXH;
      end else begin
        nonce_d = nxt[NONCE_W-1:0];
        data_d = insert_nonce(tail_q, nxt[NONCE_W-1:0], NONCE_WORD);
        state_d = S_ISSUE;
      end
    end else if (state_q == S_WAIT && wd_exp) begin
      quit_d = 1'b1;
      tout_d = 1'b1;
      state_d = S_IDLE;
    end else if (state_q == S_FOUND || state_q == S_EXH) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tail_q <= '0;
      data_q <= '0;
      diff_q <= '0;
      fhash_q <= '0;
      nonce_q <= '0;
      end_q <= '0;
      fnonce_q <= '0;
      tried_q <= '0;
      quit_q <= 1'b0;
      tout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tail_q <= tail_d;
      data_q <= data_d;
      diff_q <= diff_d;
      fhash_q <= fhash_d;
      nonce_q <= nonce_d;
      end_q <= end_d;
      fnonce_q <= fnonce_d;
      tried_q <= tried_d;
      quit_q <= quit_d;
      tout_q <= tout_d;
    end
  end
  assign busy = state_q != S_IDLE;
  assign found = state_q == S_FOUND;
  assign exhausted = state_q == S_EXH;
  assign found_nonce = fnonce_q;
  assign found_hash = fhash_q;
  assign timeout_err = tout_q;
  assign hashes_tried = tried_q;
  assign hash.begin_hash = state_q == S_ISSUE;
  assign hash.quit_hash = quit_q;
  assign hash.data_to_hash = data_q;
  assign hash.difficulty = diff_q;
endmodule

// File: tb/tb_hm_nonce_dispatch.sv
// tb_hm_nonce_dispatch: table-driven jobs plus abort/timeout/reset sequences on stride-1 and stride-4 dispatchers
module tb_hm_nonce_dispatch;
  import hm_dispatch_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic js = 1'b0;
  logic ab = 1'b0;
  logic hd = 1'b0;
  logic vf = 1'b0;
  logic [HASH_W-1:0] vh = '0;
  logic [BLOCK_W-1:0] hdr = '0;
  logic [HASH_W-1:0] jd = '0;
  logic [31:0] ns = '0;
  logic [31:0] ne = '0;
  int n_cmp = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  hm_hash_if ha();
  hm_hash_if hb();
  assign ha.hash_done = hd;
  assign ha.valid_hash_flag = vf;
  assign ha.valid_hash = vh;
  assign hb.hash_done = hd;
  assign hb.valid_hash_flag = vf;
  assign hb.valid_hash = vh;
  logic bs_a, fd_a, ex_a, to_a, bs_b, fd_b, ex_b, to_b;
  logic [31:0] fn_a, tr_a, fn_b, tr_b;
  logic [HASH_W-1:0] fh_a, fh_b;
  hm_nonce_dispatch #(.NONCE_STRIDE(1), .NONCE_WORD(3), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .job_start(js && !sel), .abort(ab && !sel), .header_tail(hdr),
    .job_difficulty(jd), .nonce_start(ns), .nonce_end(ne), .busy(bs_a), .found(fd_a),
    .found_nonce(fn_a), .found_hash(fh_a), .exhausted(ex_a), .timeout_err(to_a),
    .hashes_tried(tr_a), .hash(ha)
  );
  hm_nonce_dispatch #(.NONCE_STRIDE(4), .NONCE_WORD(3), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .rst(rst), .job_start(js && sel), .abort(ab && sel), .header_tail(hdr),
    .job_difficulty(jd), .nonce_start(ns), .nonce_end(ne), .busy(bs_b), .found(fd_b),
    .found_nonce(fn_b), .found_hash(fh_b), .exhausted(ex_b), .timeout_err(to_b),
    .hashes_tried(tr_b), .hash(hb)
  );
  logic bh_m, qh_m, bs_m, fd_m, ex_m, to_m;
  logic [31:0] fn_m, tr_m;
  logic [HASH_W-1:0] fh_m, df_m;
  logic [BLOCK_W-1:0] dt_m;
  assign bh_m = sel ? hb.begin_hash : ha.begin_hash;
  assign qh_m = sel ? hb.quit_hash : ha.quit_hash;
  assign dt_m = sel ? hb.data_to_hash : ha.data_to_hash;
  assign df_m = sel ? hb.difficulty : ha.difficulty;
  assign bs_m = sel ? bs_b : bs_a;
  assign fd_m = sel ? fd_b : fd_a;
  assign ex_m = sel ? ex_b : ex_a;
  assign to_m = sel ? to_b : to_a;
  assign fn_m = sel ? fn_b : fn_a;
  assign tr_m = sel ? tr_b : tr_a;
  assign fh_m = sel ? fh_b : fh_a;
  typedef struct {
    bit sel;
    logic [31:0] ns;
    logic [31:0] ne;
    int hit;
    int begins;
    bit fnd;
    bit exh;
    logic [31:0] fn;
    logic [31:0] tried;
  } vec_t;
  vec_t vecs[6];
  function automatic logic [HASH_W-1:0] hashf(input logic [31:0] n);
    return {8{n ^ 32'h5A5AA5A5}};
  endfunction
  task automatic chk(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic start_job(input bit s, input logic [31:0] a, input logic [31:0] b, input int j);
    sel = s;
    ns = a;
    ne = b;
    hdr = {16{32'hDEADBEEF ^ (32'h01010101 * 32'(j + 1))}};
    jd = {8{32'hC0DE0000 + 32'(j)}};
    @(negedge clk);
    js = 1'b1;
    @(negedge clk);
    js = 1'b0;
  endtask
  task automatic run_job(input vec_t v, input int j);
    int begins, fnd, exh, dones, cd;
    bit fin, exp_next;
    logic [31:0] mn, stride;
    logic [BLOCK_W-1:0] ed;
    begins = 0; fnd = 0; exh = 0; dones = 0; cd = -1; fin = 0; exp_next = 0;
    mn = v.ns;
    stride = v.sel ? 32'd4 : 32'd1;
    start_job(v.sel, v.ns, v.ne, j);
    chk("start_latency", 512'(bh_m), 512'd1);
    for (int c = 0; c < 200 && !fin; c++) begin
      if (exp_next) chk("done_latency", 512'(bh_m | fd_m | ex_m), 512'd1);
      exp_next = 0;
      hd = 1'b0;
      vf = 1'b0;
      if (bh_m) begin
        ed = hdr;
        ed[415:384] = mn;
        chk("data_to_hash", dt_m, ed);
        begins++;
        cd = 2;
      end
      if (fd_m) fnd++;
      if (ex_m) exh++;
      if (!bs_m) fin = 1;
      else if (cd == 0) begin
        hd = 1'b1;
        dones++;
        vf = (dones == v.hit);
        vh = hashf(mn);
        exp_next = 1;
        if (!vf) mn = mn + stride;
        cd = -1;
      end else if (cd > 0) cd--;
      if (!fin) @(negedge clk);
    end
    if (!fin) chk("job_timeout", 512'(fin), 512'd1);
    chk("begin_count", 512'(begins), 512'(v.begins));
    chk("found_pulses", 512'(fnd), 512'(v.fnd));
    chk("exhausted_pulses", 512'(exh), 512'(v.exh));
    chk("found_nonce", 512'(fn_m), 512'(v.fn));
    chk("found_hash", 512'(fh_m), v.fnd ? 512'(hashf(v.fn)) : 512'd0);
    chk("hashes_tried", 512'(tr_m), 512'(v.tried));
    chk("difficulty", 512'(df_m), 512'(jd));
    chk("timeout_err", 512'(to_m), 512'd0);
  endtask
  initial begin
    vecs[0] = '{0, 32'h10, 32'h1F, 4, 4, 1, 0, 32'h13, 32'd4};
    vecs[1] = '{0, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 2, 0, 1, 32'h0, 32'd2};
    vecs[2] = '{1, 32'h0, 32'd10, 0, 3, 0, 1, 32'h0, 32'd3};
    vecs[3] = '{0, 32'h50, 32'h40, 0, 1, 0, 1, 32'h0, 32'd1};
    vecs[4] = '{0, 32'h5, 32'h5, 1, 1, 1, 0, 32'h5, 32'd1};
    vecs[5] = '{1, 32'h100, 32'h10C, 3, 3, 1, 0, 32'h108, 32'd3};
    repeat (2) @(negedge clk);
    chk("reset_busy", 512'(bs_a | bs_b), 512'd0);
    chk("reset_data", ha.data_to_hash | hb.data_to_hash, 512'd0);
    chk("reset_pulses", 512'({ha.begin_hash, ha.quit_hash, fd_a, ex_a, to_a}), 512'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) run_job(vecs[i], i);
    hd = 1'b0; vf = 1'b0;
    start_job(0, 32'h10, 32'h1F, 7);
    @(negedge clk);
    @(negedge clk);
    hd = 1'b1; vf = 1'b1; vh = hashf(32'h10); ab = 1'b1;
    @(negedge clk);
    hd = 1'b0; vf = 1'b0; ab = 1'b0;
    chk("abort_quit", 512'(qh_m), 512'd1);
    chk("abort_no_found", 512'(fd_m), 512'd0);
    chk("abort_busy", 512'(bs_m), 512'd0);
    chk("abort_found_nonce", 512'(fn_m), 512'd0);
    @(negedge clk);
    chk("abort_quit_pulse", 512'(qh_m), 512'd0);
    chk("abort_found_late", 512'(fd_m), 512'd0);
    start_job(0, 32'h30, 32'h3F, 8);
    repeat (7) @(negedge clk);
    chk("timeout_early", 512'({qh_m, bs_m}), 512'b01);
    @(negedge clk);
    chk("timeout_quit", 512'(qh_m), 512'd1);
    chk("timeout_err", 512'(to_m), 512'd1);
    chk("timeout_busy", 512'(bs_m), 512'd0);
    repeat (3) @(negedge clk);
    chk("timeout_sticky", 512'({to_m, qh_m}), 512'b10);
    start_job(0, 32'h30, 32'h3F, 9);
    chk("timeout_cleared", 512'({to_m, bh_m}), 512'b01);
    ab = 1'b1;
    @(negedge clk);
    ab = 1'b0;
    chk("issue_abort", 512'({qh_m, bs_m}), 512'b10);
    start_job(0, 32'h20, 32'h2F, 10);
    @(negedge clk);
    @(negedge clk);
    hd = 1'b1; vf = 1'b0;
    @(negedge clk);
    hd = 1'b0;
    @(negedge clk);
    chk("pre_reset_tried", 512'(tr_m), 512'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_outs", 512'({bs_m, bh_m, qh_m, fd_m, ex_m, to_m}), 512'd0);
    chk("reset_mid_regs", 512'({tr_m, fn_m, fh_m, df_m}), 512'd0);
    chk("reset_mid_data", dt_m, 512'd0);
    @(negedge clk);
    chk("reset_no_quit", 512'(qh_m), 512'd0);
    rst = 1'b0;
    run_job('{0, 32'h20, 32'h22, 2, 2, 1, 0, 32'h21, 32'd2}, 11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
